// File: rtl/frame_sync_deser.sv
// -----------------------------------------------------------------------------
// frame_sync_deser
//
// Recovers frame alignment on a descrambled serial bit stream by hunting for a
// fixed sync word, confirms the alignment over LOCK_CNT consecutive frames,
// then packs the payload of every frame into bytes (first received bit lands
// in bit 7). Isolated sync misses are flywheeled; UNLOCK_CNT consecutive
// misses drop lock and restart the hunt.
//
// Frame layout: SYNC_W sync bits, then FRAME_BYTES*8 payload bits.
//
// Ports
//   clk          in   1  clock, rising edge
//   rst          in   1  asynchronous active-high reset
//   bit_in       in   1  serial data bit
//   bit_valid    in   1  bit_in is sampled only when high
//   data_out     out  8  payload byte, first received bit in bit 7
//   data_valid   out  1  one-cycle strobe qualifying data_out
//   frame_start  out  1  high with data_valid for byte 0 of each frame
//   locked       out  1  frame alignment established
//   sync_err     out  1  one-cycle pulse on a sync miss while locked
// -----------------------------------------------------------------------------
module frame_sync_deser #(
  parameter int                SYNC_W      = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = 16'hF628,
  parameter int                FRAME_BYTES = 8,
  parameter int                LOCK_CNT    = 2,
  parameter int                UNLOCK_CNT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  localparam int PAY_BITS = FRAME_BYTES * 8;
  localparam int BC_W     = $clog2(PAY_BITS);
  localparam int SC_W     = $clog2(SYNC_W);
  localparam int HIT_W    = $clog2(LOCK_CNT + 1);
  localparam int MISS_W   = $clog2(UNLOCK_CNT + 1);

  localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(PAY_BITS - 1);
  localparam logic [BC_W:0]     BC_BYTE1  = (BC_W + 1)'(8);
  localparam logic [SC_W-1:0]   SC_LAST   = SC_W'(SYNC_W - 1);
  localparam logic [HIT_W-1:0]  HIT_LOCK  = HIT_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state_q,       state_d;
  logic [SYNC_W-2:0]   sr_q,          sr_d;
  logic [6:0]          byte_sr_q,     byte_sr_d;
  logic [BC_W-1:0]     bit_cnt_q,     bit_cnt_d;
  logic [SC_W-1:0]     sync_cnt_q,    sync_cnt_d;
  logic                in_sync_q,     in_sync_d;
  logic [HIT_W-1:0]    hits_q,        hits_d;
  logic [MISS_W-1:0]   misses_q,      misses_d;
  logic [7:0]          data_out_q,    data_out_d;
  logic                data_valid_q,  data_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                locked_q,      locked_d;
  logic                sync_err_q,    sync_err_d;

  // The sync window holds only SYNC_W-1 past bits; the current bit completes it.
  logic [SYNC_W-1:0] win;
  logic              match;

  assign win   = {sr_q, bit_in};
  assign match = (win == SYNC_WORD);

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    byte_sr_d     = byte_sr_q;
    bit_cnt_d     = bit_cnt_q;
    sync_cnt_d    = sync_cnt_q;
    in_sync_d     = in_sync_q;
    hits_d        = hits_q;
    misses_d      = misses_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    locked_d      = locked_q;
    sync_err_d    = 1'b0;

    if (bit_valid) begin
      sr_d      = win[SYNC_W-2:0];
      // Separate byte shifter so byte packing does not depend on SYNC_W >= 8.
      byte_sr_d = {byte_sr_q[5:0], bit_in};

      case (state_q)
        HUNT: begin
          // Sliding search on every valid bit; aliasing inside payload is
          // weeded out later by VERIFY.
          if (match) begin
            hits_d     = HIT_W'(1);
            misses_d   = '0;
            bit_cnt_d  = '0;
            sync_cnt_d = '0;
            in_sync_d  = 1'b0;
            if (LOCK_CNT == 1) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end else begin
              state_d  = VERIFY;
            end
          end
        end

        default: begin
          if (!in_sync_q) begin
            // Payload field: bytes leave only once lock is confirmed.
            if (state_q == LOCKED && bit_cnt_q[2:0] == 3'd7) begin
              data_out_d    = {byte_sr_q, bit_in};
              data_valid_d  = 1'b1;
              frame_start_d = ({1'b0, bit_cnt_q} < BC_BYTE1);
            end
            if (bit_cnt_q == BC_LAST) begin
              bit_cnt_d  = '0;
              sync_cnt_d = '0;
              in_sync_d  = 1'b1;
            end else begin
              bit_cnt_d  = bit_cnt_q + BC_W'(1);
            end
          end else if (sync_cnt_q != SC_LAST) begin
            sync_cnt_d = sync_cnt_q + SC_W'(1);
          end else begin
            // Last sync bit: the window now holds exactly the sync field.
            sync_cnt_d = '0;
            bit_cnt_d  = '0;
            in_sync_d  = 1'b0;
            if (state_q == VERIFY) begin
              if (match) begin
                hits_d = hits_q + HIT_W'(1);
                if (hits_q + HIT_W'(1) == HIT_LOCK) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                end
              end else begin
                hits_d  = '0;
                state_d = HUNT;
              end
            end else begin
              if (match) begin
                misses_d = '0;
              end else begin
                sync_err_d = 1'b1;
                if (misses_q + MISS_W'(1) == MISS_DROP) begin
                  misses_d = '0;
                  hits_d   = '0;
                  locked_d = 1'b0;
                  state_d  = HUNT;
                end else begin
                  // Flywheel: keep the assumed alignment for the next frame.
                  misses_d = misses_q + MISS_W'(1);
                end
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      sr_q          <= '0;
      byte_sr_q     <= '0;
      bit_cnt_q     <= '0;
      sync_cnt_q    <= '0;
      in_sync_q     <= 1'b0;
      hits_q        <= '0;
      misses_q      <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      byte_sr_q     <= byte_sr_d;
      bit_cnt_q     <= bit_cnt_d;
      sync_cnt_q    <= sync_cnt_d;
      in_sync_q     <= in_sync_d;
      hits_q        <= hits_d;
      misses_q      <= misses_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

endmodule

// File: doc/frame_sync_deser.md
Name: frame_sync_deser

Overview:
- Consumes the descrambled serial bit stream and recovers frame alignment by hunting for a fixed sync word.
- Once aligned, packs payload bits into bytes.
- Confirms lock over consecutive frames before releasing data.
- Flywheels through isolated sync errors and drops lock after repeated misses.
- Feeds the byte-level receive logic.

Parameters:
- SYNC_W, 16, sync word width in bits (≥ 2)
- SYNC_WORD, 16'hF628, expected sync pattern, first received bit = MSB
- FRAME_BYTES, 8, payload bytes following each sync word
- LOCK_CNT, 2, consecutive sync matches needed to declare lock (≥ 1)
- UNLOCK_CNT, 3, consecutive sync misses while locked that force loss of lock (≥ 1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is sampled on a rising clk edge only when high
- data_out  output  8  payload byte, first received bit in bit 7
- data_valid  output  1  one-cycle strobe, data_out valid
- frame_start  output  1  high together with data_valid for byte 0 of each frame
- locked  output  1  frame alignment established
- sync_err  output  1  one-cycle pulse on a sync miss while locked

Behaviour:
- Reset (asynchronous, rst=1): all outputs, shift register, counters and the hit/miss counters cleared to 0; state = HUNT.
  - Reset takes effect immediately, including mid-byte or mid-frame; any partial byte is discarded.
- Sampling:
  - Every update below happens only on a clock edge with bit_valid=1.
  - bit_valid=0 freezes all state. data_valid, frame_start and sync_err are still cleared on that edge.
- Sync window: win = {sr[SYNC_W-2:0], bit_in}, i.e. the last SYNC_W valid bits including the current one. match = (win == SYNC_WORD).
- Frame layout: SYNC_W sync bits, then FRAME_BYTES*8 payload bits.
  - bit_cnt counts payload bits, 0 to FRAME_BYTES*8-1.
  - After the last payload bit, the next SYNC_W bits are the sync field. sync_cnt counts 0 to SYNC_W-1; evaluate match on sync_cnt == SYNC_W-1.
- HUNT:
  - On match: hits ← 1, bit_cnt ← 0. If LOCK_CNT == 1, go to LOCKED (locked ← 1); otherwise go to VERIFY.
  - No data output in HUNT.
- VERIFY:
  - Payload bits are counted but not output.
  - At the sync check, match: hits+1. If hits+1 == LOCK_CNT, go to LOCKED with locked ← 1; otherwise stay in VERIFY.
  - At the sync check, miss: hits ← 0, go to HUNT. Hunting restarts on the next valid bit, using the full window.
- LOCKED:
  - Bytes: every 8th payload bit sets data_out ← {byte_sr[6:0], bit_in} and pulses data_valid for one cycle, on the edge that samples that bit (registered output).
  - frame_start = 1 on the byte with bit_cnt in 0..7.
  - Sync check, match: misses ← 0.
  - Sync check, miss: sync_err pulses, misses+1.
    - If misses+1 < UNLOCK_CNT: stay in LOCKED and output the following frame normally (flywheel).
    - If misses+1 == UNLOCK_CNT: locked ← 0, hits ← 0, misses ← 0, state ← HUNT; sync_err still pulses on that edge.
- locked is a registered output. It is high in LOCKED only, and changes on the edge that evaluates the deciding sync bit.
- Counter widths: bit_cnt = $clog2(FRAME_BYTES*8); sync_cnt = $clog2(SYNC_W); hits and misses sized to hold LOCK_CNT and UNLOCK_CNT.
- Sync-pattern aliasing inside the payload during HUNT is acceptable. VERIFY rejects such false alignments.

Test Plan:
- Reset: hold rst=1 with random bit_in and bit_valid → data_out=0, data_valid=0, frame_start=0, locked=0, sync_err=0. Assert rst mid-frame while locked → locked falls without waiting for clk.
- Acquisition (defaults): 40 bits that do not contain the sync pattern, then 3 frames of F628 + bytes 00..07 with bit_valid=1 continuously → no data_valid in frame 1.
  - locked rises on the edge sampling the last sync bit of frame 2.
  - Frame 2 outputs 00..07 with frame_start only on 00; frame 3 repeats the same.
- Gapped input: the same stream with bit_valid randomly 0 on ~30% of cycles → identical byte sequence and lock point (counted in valid bits).
- Flywheel: once locked, corrupt the sync of frame N to F629 → one sync_err pulse, locked stays 1, frame N payload is still output. Then 3 consecutive corrupted syncs → locked falls at the third, 3 sync_err pulses, no data_valid afterwards. A clean stream regains lock after 2 syncs.
- VERIFY reject: a valid sync, then a wrong sync 80 bits later → state returns to HUNT, locked never rises, no data_valid.
- LOCK_CNT=1, UNLOCK_CNT=1 build: the first matching sync locks immediately and the next payload is output; a single sync miss drops lock.
